// File: rtl/seg_pkg.sv
// Shared widths, converter state encoding, segment constants and the digit-to-segment table
// for the 7-segment display slice.
package seg_pkg;

  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CONVERT = 2'b01;
  localparam logic [1:0] ST_COMMIT  = 2'b10;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;

  // Snapshot of what the display currently shows
  typedef struct packed {
    logic             neg;
    logic [BCD_W-1:0] bcd;
  } disp_t;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows blank
  function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_display_if.sv
// Bundle between the CPU output port side (master) and the display driver (slave).
interface seven_seg_display_if;
  import seg_pkg::*;

  logic [BIN_W-1:0] value;
  logic             signed_mode;
  logic [SEG_W-1:0] seg_n;
  logic             dp_n;
  logic [AN_W-1:0]  an_n;
  logic             busy;
  logic [BCD_W-1:0] bcd_out;
  logic             neg_out;

  modport master (
    output value, signed_mode,
    input  seg_n, dp_n, an_n, busy, bcd_out, neg_out
  );

  modport slave (
    input  value, signed_mode,
    output seg_n, dp_n, an_n, busy, bcd_out, neg_out
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, 8 steps, then a one-cycle commit
// state during which done is high.
module bin_to_bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam int unsigned CAT_W = BCD_W + BIN_W;

  logic [1:0]       state, state_nxt;
  logic [BIN_W-1:0] shift, shift_nxt;
  logic [BCD_W-1:0] acc, acc_nxt, adj;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CAT_W-1:0] cat;
  logic             busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      shift <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    adj       = acc;
    // Add 3 to every nibble >= 5 before the shift so it carries correctly into the next decade
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    cat = {adj, shift} << 1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CONVERT;
          shift_nxt = bin;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_CONVERT: begin
        acc_nxt   = cat[CAT_W-1:BIN_W];
        shift_nxt = cat[BIN_W-1:0];
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_COMMIT);
  end

  assign bcd = acc;

endmodule

// File: rtl/seven_seg_display.sv
// Converts the CPU output port to signed/unsigned decimal and time-multiplexes it onto a
// 4-digit common-anode display with optional leading-zero blanking.
module seven_seg_display
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic               clk,
  input logic               reset,
  seven_seg_display_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);

  logic [BIN_W:0]    pair, cap;
  logic              neg_c, cap_neg, start_c;
  logic [BIN_W-1:0]  mag_c;
  logic              conv_busy, conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  disp_t             shown;
  logic              shown_valid;
  logic [PRE_W-1:0]  presc;
  logic [1:0]        idx;
  logic [AN_W-1:0]   an;
  logic [SEG_W-1:0]  seg_c;
  logic [3:0]        hun, ten, one;

  assign pair    = {bus.signed_mode, bus.value};
  assign neg_c   = bus.signed_mode & bus.value[BIN_W-1];
  assign mag_c   = neg_c ? BIN_W'(~bus.value + 1'b1) : bus.value;
  // Only restart when idle, so a changed input is picked up once the current result commits
  assign start_c = !conv_busy && (!shown_valid || (pair != cap));

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .bin   (mag_c),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap         <= '0;
      cap_neg     <= 1'b0;
      shown       <= '0;
      shown_valid <= 1'b0;
    end else begin
      if (start_c) begin
        cap     <= pair;
        cap_neg <= neg_c;
      end
      if (conv_done) begin
        shown.bcd   <= conv_bcd;
        shown.neg   <= cap_neg;
        shown_valid <= 1'b1;
      end
    end
  end

  // Digit scan, free-running and independent of the converter
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1110;
    end else if (presc == PRE_W'(CLK_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
      an    <= {an[AN_W-2:0], an[AN_W-1]};
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign hun = shown.bcd[11:8];
  assign ten = shown.bcd[7:4];
  assign one = shown.bcd[3:0];

  always_comb begin
    seg_c = SEG_BLANK;
    if (shown_valid) begin
      case (idx)
        2'd0: seg_c = seg_digit(one);
        2'd1: seg_c = (BLANK_LEADING && hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : seg_digit(ten);
        2'd2: seg_c = (BLANK_LEADING && hun == 4'd0) ? SEG_BLANK : seg_digit(hun);
        default: seg_c = shown.neg ? SEG_MINUS : SEG_BLANK;
      endcase
    end
  end

  assign bus.seg_n   = seg_c;
  assign bus.dp_n    = 1'b1;
  assign bus.an_n    = an;
  assign bus.busy    = conv_busy;
  assign bus.bcd_out = shown.bcd;
  assign bus.neg_out = shown.neg;

endmodule

// File: tb/tb_seven_seg_display.sv
// Randomized and directed bench for seven_seg_display; expectations come from a decimal model
// of the display rules, with a blanking and a non-blanking instance sharing one stimulus.
module tb_seven_seg_display;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seven_seg_display_if bus_a ();
  seven_seg_display_if bus_b ();

  seven_seg_display #(.CLK_DIV(4), .BLANK_LEADING(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seven_seg_display #(.CLK_DIV(4), .BLANK_LEADING(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model
  function automatic int ref_mag(input logic [7:0] v, input logic sm);
    return (sm && v[7]) ? 256 - int'(v) : int'(v);
  endfunction

  function automatic logic ref_neg(input logic [7:0] v, input logic sm);
    return sm && v[7];
  endfunction

  function automatic logic [11:0] ref_bcd(input logic [7:0] v, input logic sm);
    int m;
    m = ref_mag(v, sm);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [7:0] v, input logic sm, input int slot, input bit blank);
    int m;
    m = ref_mag(v, sm);
    case (slot)
      0: return seg_tab[m % 10];
      1: return (blank && m < 10) ? 7'h7F : seg_tab[(m / 10) % 10];
      2: return (blank && m < 100) ? 7'h7F : seg_tab[m / 100];
      default: return ref_neg(v, sm) ? 7'h3F : 7'h7F;
    endcase
  endfunction

  // Stimulus / observation helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic sm);
    bus_a.value = v; bus_a.signed_mode = sm;
    bus_b.value = v; bus_b.signed_mode = sm;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bus_a.busy && !bus_b.busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic scan_slot(input bit which, input int slot, output logic [6:0] seg, output bit ok);
    logic [3:0] want, an;
    want = ~(4'b0001 << slot);
    ok = 1'b0;
    seg = 7'h00;
    for (int i = 0; i < 40; i++) begin
      an = which ? bus_b.an_n : bus_a.an_n;
      if (an == want) begin
        seg = which ? bus_b.seg_n : bus_a.seg_n;
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b0;
    drive(8'h00, 1'b0);
    repeat (5) step();
    checks++; if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.bcd_out !== 12'h000) begin fails++; $display("FAIL reset_bcd: got %h expected 000", bus_a.bcd_out); end
    checks++; if (bus_a.neg_out !== 1'b0) begin fails++; $display("FAIL reset_neg: got %b expected 0", bus_a.neg_out); end
    checks++; if (bus_a.an_n !== 4'b1110) begin fails++; $display("FAIL reset_an: got %b expected 1110", bus_a.an_n); end
    checks++; if (bus_a.seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h expected 7f", bus_a.seg_n); end
    checks++; if (bus_a.dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b expected 1", bus_a.dp_n); end
  endtask

  task automatic test_first_conversion();
    logic [6:0] seg;
    bit ok;
    reset = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL first_busy_%0d: got %b expected 1", i, bus_a.busy); end
      if (i < 8) step();
    end
    step();
    checks++; if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL first_busy_end: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.bcd_out !== 12'h000) begin fails++; $display("FAIL first_bcd: got %h expected 000", bus_a.bcd_out); end
    for (int s = 0; s < 4; s++) begin
      scan_slot(1'b0, s, seg, ok);
      checks++; if (!ok || seg !== ref_seg(8'h00, 1'b0, s, 1'b1)) begin
        fails++; $display("FAIL first_seg_%0d: got %h ok %b expected %h", s, seg, ok, ref_seg(8'h00, 1'b0, s, 1'b1)); end
    end
  endtask

  task automatic test_scan_ff();
    logic [6:0] seg;
    logic [3:0] an0;
    bit ok;
    int n;
    drive(8'hFF, 1'b0);
    step();
    wait_idle(30, ok);
    checks++; if (!ok || bus_a.bcd_out !== ref_bcd(8'hFF, 1'b0)) begin
      fails++; $display("FAIL ff_bcd: got %h ok %b expected %h", bus_a.bcd_out, ok, ref_bcd(8'hFF, 1'b0)); end
    for (int s = 0; s < 4; s++) begin
      scan_slot(1'b0, s, seg, ok);
      checks++; if (!ok || seg !== ref_seg(8'hFF, 1'b0, s, 1'b1)) begin
        fails++; $display("FAIL ff_seg_%0d: got %h ok %b expected %h", s, seg, ok, ref_seg(8'hFF, 1'b0, s, 1'b1)); end
    end
    // Slot length: wait for a digit change, then count cycles to the next one
    an0 = bus_a.an_n;
    for (int i = 0; i < 10 && bus_a.an_n == an0; i++) step();
    an0 = bus_a.an_n;
    n = 0;
    while (bus_a.an_n == an0 && n < 20) begin step(); n++; end
    checks++; if (n != 4) begin fails++; $display("FAIL scan_period: got %0d expected 4", n); end
  endtask

  task automatic test_signed();
    logic [6:0] seg;
    bit ok;
    for (int m = 1; m >= 0; m--) begin
      drive(8'h80, 1'(m));
      step();
      wait_idle(30, ok);
      checks++; if (!ok || bus_a.bcd_out !== 12'h128) begin
        fails++; $display("FAIL s80_bcd_m%0d: got %h ok %b expected 128", m, bus_a.bcd_out, ok); end
      checks++; if (bus_a.neg_out !== ref_neg(8'h80, 1'(m))) begin
        fails++; $display("FAIL s80_neg_m%0d: got %b expected %b", m, bus_a.neg_out, ref_neg(8'h80, 1'(m))); end
      scan_slot(1'b0, 3, seg, ok);
      checks++; if (!ok || seg !== ref_seg(8'h80, 1'(m), 3, 1'b1)) begin
        fails++; $display("FAIL s80_sign_m%0d: got %h expected %h", m, seg, ref_seg(8'h80, 1'(m), 3, 1'b1)); end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] seg;
    bit ok;
    drive(8'hF9, 1'b1);
    step();
    wait_idle(30, ok);
    checks++; if (!ok || bus_a.bcd_out !== 12'h007 || bus_a.neg_out !== 1'b1) begin
      fails++; $display("FAIL f9_result: got %h/%b expected 007/1", bus_a.bcd_out, bus_a.neg_out); end
    for (int s = 0; s < 4; s++) begin
      scan_slot(1'b0, s, seg, ok);
      checks++; if (!ok || seg !== ref_seg(8'hF9, 1'b1, s, 1'b1)) begin
        fails++; $display("FAIL f9_blank_seg_%0d: got %h expected %h", s, seg, ref_seg(8'hF9, 1'b1, s, 1'b1)); end
      scan_slot(1'b1, s, seg, ok);
      checks++; if (!ok || seg !== ref_seg(8'hF9, 1'b1, s, 1'b0)) begin
        fails++; $display("FAIL f9_noblank_seg_%0d: got %h expected %h", s, seg, ref_seg(8'hF9, 1'b1, s, 1'b0)); end
    end
  endtask

  task automatic test_back_to_back();
    drive(8'd5, 1'b0);
    step();
    step();
    step();
    drive(8'd200, 1'b0);
    repeat (6) step();
    checks++; if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy1: got %b expected 1", bus_a.busy); end
    step();
    checks++; if (bus_a.busy !== 1'b0 || bus_a.bcd_out !== 12'h005) begin
      fails++; $display("FAIL b2b_first: got busy %b bcd %h expected 0/005", bus_a.busy, bus_a.bcd_out); end
    step();
    checks++; if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL b2b_rebusy: got %b expected 1", bus_a.busy); end
    repeat (8) step();
    checks++; if (bus_a.busy !== 1'b1 || bus_a.bcd_out !== 12'h005) begin
      fails++; $display("FAIL b2b_hold: got busy %b bcd %h expected 1/005", bus_a.busy, bus_a.bcd_out); end
    step();
    checks++; if (bus_a.busy !== 1'b0 || bus_a.bcd_out !== ref_bcd(8'd200, 1'b0)) begin
      fails++; $display("FAIL b2b_second: got busy %b bcd %h expected 0/%h", bus_a.busy, bus_a.bcd_out, ref_bcd(8'd200, 1'b0)); end
  endtask

  task automatic test_reset_mid();
    drive(8'h9C, 1'b1);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (bus_a.busy !== 1'b0 || bus_a.bcd_out !== 12'h000 || bus_a.neg_out !== 1'b0) begin
      fails++; $display("FAIL rmid_regs: got busy %b bcd %h neg %b expected 0/000/0", bus_a.busy, bus_a.bcd_out, bus_a.neg_out); end
    checks++; if (bus_a.an_n !== 4'b1110 || bus_a.seg_n !== 7'h7F || bus_a.dp_n !== 1'b1) begin
      fails++; $display("FAIL rmid_disp: got an %b seg %h dp %b expected 1110/7f/1", bus_a.an_n, bus_a.seg_n, bus_a.dp_n); end
    reset = 1'b1;
    step();
    repeat (8) step();
    checks++; if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b expected 1", bus_a.busy); end
    step();
    checks++; if (bus_a.bcd_out !== ref_bcd(8'h9C, 1'b1) || bus_a.neg_out !== 1'b1) begin
      fails++; $display("FAIL rmid_result: got %h/%b expected %h/1", bus_a.bcd_out, bus_a.neg_out, ref_bcd(8'h9C, 1'b1)); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic sm;
    logic [6:0] seg;
    bit ok;
    for (int n = 0; n < 20; n++) begin
      v  = 8'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      drive(v, sm);
      step();
      wait_idle(30, ok);
      checks++; if (!ok || bus_a.bcd_out !== ref_bcd(v, sm) || bus_a.neg_out !== ref_neg(v, sm)) begin
        fails++; $display("FAIL rnd_a v=%h sm=%b: got %h/%b expected %h/%b", v, sm, bus_a.bcd_out, bus_a.neg_out, ref_bcd(v, sm), ref_neg(v, sm)); end
      checks++; if (bus_b.bcd_out !== ref_bcd(v, sm)) begin
        fails++; $display("FAIL rnd_b v=%h sm=%b: got %h expected %h", v, sm, bus_b.bcd_out, ref_bcd(v, sm)); end
      for (int s = 0; s < 4; s++) begin
        scan_slot(1'b0, s, seg, ok);
        checks++; if (!ok || seg !== ref_seg(v, sm, s, 1'b1)) begin
          fails++; $display("FAIL rnd_seg_a v=%h sm=%b slot %0d: got %h expected %h", v, sm, s, seg, ref_seg(v, sm, s, 1'b1)); end
        scan_slot(1'b1, s, seg, ok);
        checks++; if (!ok || seg !== ref_seg(v, sm, s, 1'b0)) begin
          fails++; $display("FAIL rnd_seg_b v=%h sm=%b slot %0d: got %h expected %h", v, sm, s, seg, ref_seg(v, sm, s, 1'b0)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_conversion();
    test_scan_ff();
    test_signed();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
